// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between a scan requester / downstream 2:1 mux and mux_scan_ctrl.
interface mux_scan_ctrl_if;
   logic Start;
   logic Cont;
   logic En0;
   logic En1;
   logic Y;
   logic S;
   logic Sample0;
   logic Sample1;
   logic Valid;
   logic Busy;

   modport master (
      output Start, Cont, En0, En1, Y,
      input  S, Sample0, Sample1, Valid, Busy
   );

   modport slave (
      input  Start, Cont, En0, En1, Y,
      output S, Sample0, Sample1, Valid, Busy
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans the two inputs of an external 2:1 mux: drives its select, lets it settle,
// majority-votes DWELL samples of its output per enabled channel, then pulses Valid.
module mux_scan_ctrl #(
   parameter int DWELL  = 4,
   parameter int SETTLE = 1
) (
   input logic            Clk,
   input logic            Reset_n,
   mux_scan_ctrl_if.slave bus
);
   localparam int         OW          = $clog2(DWELL + 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [7:0] DWELL_LAST  = 8'(DWELL - 1);
   localparam logic [9:0] DWELL_THR   = 10'(DWELL);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DWELL  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // With no settle time a channel goes straight into sampling.
   localparam state_t FIRST_PHASE = (SETTLE == 0) ? ST_DWELL : ST_SETTLE;

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [OW-1:0] ones_q, ones_d;
   logic          en0_q, en0_d;
   logic          en1_q, en1_d;
   logic          s_q, s_d;
   logic          sample0_q, sample0_d;
   logic          sample1_q, sample1_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic [OW-1:0] ones_sum_s;
   logic          vote_s;

   // State register and registered outputs, synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         ones_q    <= '0;
         en0_q     <= 1'b0;
         en1_q     <= 1'b0;
         s_q       <= 1'b0;
         sample0_q <= 1'b0;
         sample1_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ones_q    <= ones_d;
         en0_q     <= en0_d;
         en1_q     <= en1_d;
         s_q       <= s_d;
         sample0_q <= sample0_d;
         sample1_q <= sample1_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state, counter and output computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ones_d     = ones_q;
      en0_d      = en0_q;
      en1_d      = en1_q;
      s_d        = s_q;
      sample0_d  = sample0_q;
      sample1_d  = sample1_q;
      // Vote includes the sample taken on the current edge; a tie votes 0.
      ones_sum_s = ones_q + OW'(bus.Y);
      vote_s     = (10'(ones_sum_s) + 10'(ones_sum_s)) > DWELL_THR;

      case (state_q)
         ST_IDLE: begin
            if (bus.Start && (bus.En0 || bus.En1)) begin
               en0_d   = bus.En0;
               en1_d   = bus.En1;
               s_d     = ~bus.En0;
               cnt_d   = 8'd0;
               ones_d  = '0;
               state_d = FIRST_PHASE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = 8'd0;
               state_d = ST_DWELL;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         ST_DWELL: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d  = 8'd0;
               ones_d = '0;
               if (s_q) begin
                  sample1_d = vote_s;
               end else begin
                  sample0_d = vote_s;
               end
               // Channel 1 follows channel 0 only when it was latched enabled.
               if (!s_q && en0_q && en1_q) begin
                  s_d     = 1'b1;
                  state_d = FIRST_PHASE;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d  = cnt_q + 8'd1;
               ones_d = ones_sum_s;
            end
         end
         ST_DONE: begin
            if (bus.Cont && (bus.En0 || bus.En1)) begin
               en0_d   = bus.En0;
               en1_d   = bus.En1;
               s_d     = ~bus.En0;
               cnt_d   = 8'd0;
               ones_d  = '0;
               state_d = FIRST_PHASE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Valid is registered off DONE, so it lands one edge after the DONE state.
      valid_d = (state_q == ST_DONE);
      busy_d  = (state_d != ST_IDLE);
   end

   assign bus.S       = s_q;
   assign bus.Sample0 = sample0_q;
   assign bus.Sample1 = sample1_q;
   assign bus.Valid   = valid_q;
   assign bus.Busy    = busy_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench for mux_scan_ctrl; two instances cover the default
// timing (DWELL=4, SETTLE=1) and the minimum timing (DWELL=1, SETTLE=0).
module tb_mux_scan_ctrl;
   localparam int DW_A = 4;
   localparam int ST_A = 1;
   localparam int DW_B = 1;
   localparam int ST_B = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   fails   = 0;
   bit   exp_smp [2][2];

   mux_scan_ctrl_if bus_a ();
   mux_scan_ctrl_if bus_b ();

   mux_scan_ctrl #(.DWELL(DW_A), .SETTLE(ST_A)) dut_a (.Clk(clk), .Reset_n(rst_n), .bus(bus_a));
   mux_scan_ctrl #(.DWELL(DW_B), .SETTLE(ST_B)) dut_b (.Clk(clk), .Reset_n(rst_n), .bus(bus_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs_v, input logic exp_v);
      vectors++;
      assert (obs_v === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
      end
   endtask

   // {S, Sample0, Sample1, Valid, Busy}
   function automatic logic [4:0] obs(input bit w);
      if (w) return {bus_b.S, bus_b.Sample0, bus_b.Sample1, bus_b.Valid, bus_b.Busy};
      else   return {bus_a.S, bus_a.Sample0, bus_a.Sample1, bus_a.Valid, bus_a.Busy};
   endfunction

   task automatic drive(input bit w, input bit st, input bit co, input bit e0, input bit e1);
      if (w) begin
         bus_b.Start = st; bus_b.Cont = co; bus_b.En0 = e0; bus_b.En1 = e1;
      end else begin
         bus_a.Start = st; bus_a.Cont = co; bus_a.En0 = e0; bus_a.En1 = e1;
      end
   endtask

   task automatic set_y(input bit w, input bit y);
      if (w) bus_b.Y = y;
      else   bus_a.Y = y;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input bit w, input string tag);
      logic [4:0] o;
      o = obs(w);
      chk({tag, "_s"}, o[4], 1'b0);
      chk({tag, "_sample0"}, o[3], 1'b0);
      chk({tag, "_sample1"}, o[2], 1'b0);
      chk({tag, "_valid"}, o[1], 1'b0);
      chk({tag, "_busy"}, o[0], 1'b0);
   endtask

   // Called at a negedge; the following rising edge is the Start-sampling edge.
   task automatic launch(input bit w, input bit e0, input bit e1, input bit co);
      drive(w, 1'b1, co, e0, e1);
      step();
      drive(w, 1'b0, co, e0, e1);
   endtask

   // Follows one scan from the negedge after its launch edge to the Valid cycle.
   // Y comes from a mux model on the observed S; expectations use the channel the
   // scan schedule says should be selected.
   task automatic track_scan(input bit w, input bit e0, input bit e1,
                             input bit launch_valid, input bit end_busy, input bit noise);
      int set, dw, p, n, ones, idx;
      bit ch [2];
      bit i0, i1;
      logic [4:0] o;
      set  = w ? ST_B : ST_A;
      dw   = w ? DW_B : DW_A;
      p    = set + dw;
      n    = 0;
      ones = 0;
      ch[0] = 1'b0;
      ch[1] = 1'b1;
      if (e0) begin ch[n] = 1'b0; n++; end
      if (e1) begin ch[n] = 1'b1; n++; end
      for (int j = 0; j <= n * p; j++) begin
         idx = (j / p < n) ? j / p : n - 1;
         o = obs(w);
         chk("busy_scan", o[0], 1'b1);
         chk("valid_scan", o[1], (j == 0) ? launch_valid : 1'b0);
         chk("s_scan", o[4], ch[idx]);
         if (j < n * p) begin
            i0 = 1'($urandom_range(0, 1));
            i1 = 1'($urandom_range(0, 1));
            set_y(w, o[4] ? i1 : i0);
            if (j % p >= set) ones += ch[idx] ? int'(i1) : int'(i0);
            if (j % p == p - 1) begin
               exp_smp[w][ch[idx]] = (2 * ones > dw);
               ones = 0;
            end
         end
         if (noise) drive(w, 1'($urandom_range(0, 1)), 1'b0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         step();
         o = obs(w);
         chk("sample0", o[3], exp_smp[w][0]);
         chk("sample1", o[2], exp_smp[w][1]);
      end
      o = obs(w);
      chk("valid_end", o[1], 1'b1);
      chk("busy_end", o[0], end_busy);
      if (noise) drive(w, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_check(input bit w, input int cycles, input bit exp_s);
      logic [4:0] o;
      for (int k = 0; k < cycles; k++) begin
         step();
         o = obs(w);
         chk("idle_busy", o[0], 1'b0);
         chk("idle_valid", o[1], 1'b0);
         chk("idle_s", o[4], exp_s);
         chk("idle_sample0", o[3], exp_smp[w][0]);
         chk("idle_sample1", o[2], exp_smp[w][1]);
      end
   endtask

   initial begin
      bit e0, e1, nz;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      set_y(1'b0, 1'b0);
      set_y(1'b1, 1'b0);
      for (int w = 0; w < 2; w++) for (int c = 0; c < 2; c++) exp_smp[w][c] = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      check_all_zero(1'b0, "reset_a");
      check_all_zero(1'b1, "reset_b");
      rst_n = 1'b1;

      // Both channels, then channel 1 alone; S must sit at 1 in IDLE afterwards.
      launch(1'b0, 1'b1, 1'b1, 1'b0);
      track_scan(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check(1'b0, 2, 1'b1);
      launch(1'b0, 1'b0, 1'b1, 1'b0);
      track_scan(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check(1'b0, 1, 1'b1);
      launch(1'b0, 1'b1, 1'b0, 1'b0);
      track_scan(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_check(1'b0, 1, 1'b0);

      // Start with nothing enabled is ignored.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check(1'b0, 3, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random enables; Start/En toggling mid-scan must not disturb the scan.
      for (int r = 0; r < 8; r++) begin
         e0 = 1'($urandom_range(0, 1));
         e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
         nz = 1'($urandom_range(0, 1));
         launch(1'b0, e0, e1, 1'b0);
         track_scan(1'b0, e0, e1, 1'b0, 1'b0, nz);
         idle_check(1'b0, 1, e1);
      end

      // Continuous mode: back-to-back scans, then Cont dropped mid-scan.
      launch(1'b0, 1'b1, 1'b1, 1'b1);
      track_scan(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      track_scan(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      track_scan(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_check(1'b0, 2, 1'b1);

      // Reset during channel 1 dwell, with Start and Cont high on the reset edge.
      launch(1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 7; k++) begin
         set_y(1'b0, 1'($urandom_range(0, 1)));
         step();
      end
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      check_all_zero(1'b0, "midreset");
      for (int w = 0; w < 2; w++) for (int c = 0; c < 2; c++) exp_smp[w][c] = 1'b0;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_check(1'b0, 1, 1'b0);
      launch(1'b0, 1'b1, 1'b1, 1'b0);
      track_scan(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check(1'b0, 1, 1'b1);

      // Minimum timing instance: one cycle per channel.
      launch(1'b1, 1'b1, 1'b1, 1'b0);
      track_scan(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check(1'b1, 1, 1'b1);
      for (int r = 0; r < 6; r++) begin
         e0 = 1'($urandom_range(0, 1));
         e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
         launch(1'b1, e0, e1, 1'b0);
         track_scan(1'b1, e0, e1, 1'b0, 1'b0, 1'b0);
         idle_check(1'b1, 1, e1);
      end
      launch(1'b1, 1'b1, 1'b1, 1'b1);
      track_scan(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      track_scan(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_check(1'b1, 2, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 4: Y samples taken per channel; legal range 1..255.
REQ-002 Parameter SETTLE, default 1: wait cycles after S changes before sampling; legal range 0..255; 0 skips the settle phase.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  synchronous, active-low reset, sampled on rising Clk.
REQ-005 Start  input  1  scan request, sampled in IDLE only.
REQ-006 Cont  input  1  continuous mode; when 1, a new scan begins automatically after DONE.
REQ-007 En0, En1  input  1 each  channel enables, latched at scan start.
REQ-008 Y  input  1  output of the downstream 2:1 mux (I0 selected when S=0, I1 when S=1).
REQ-009 S  output  1  select line driven into the 2:1 mux; registered.
REQ-010 Sample0, Sample1  output  1 each  majority-voted value per channel; registered.
REQ-011 Valid  output  1  one-cycle pulse when a scan completes.
REQ-012 Busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, SETTLE, DWELL, DONE.
REQ-014 IDLE: on Start=1 with (En0|En1)=1, latch En0/En1 and move to SETTLE, or to DWELL if SETTLE=0; S = lowest enabled channel; counters cleared.
REQ-015 IDLE: Start with En0=En1=0 SHALL be ignored and the block SHALL stay in IDLE.
REQ-016 SETTLE: hold for exactly SETTLE cycles, no sampling, then enter DWELL.
REQ-017 DWELL: on each of DWELL consecutive edges, add Y to a ones-counter of width ceil(log2(DWELL+1)).
REQ-018 End of DWELL: the current channel's Sample SHALL load (2*ones > DWELL); a tie SHALL load 0.
REQ-019 After a channel's DWELL, if the other channel is latched enabled and not yet scanned, toggle S, clear counters, and enter SETTLE (or DWELL if SETTLE=0); otherwise enter DONE.
REQ-020 Channel order SHALL be 0 then 1; disabled channels SHALL be skipped; a skipped channel's Sample SHALL keep its previous value.
REQ-021 DONE lasts exactly one cycle with Valid=1; next state is SETTLE/DWELL (restart per REQ-014 using current En0/En1) if Cont=1 and (En0|En1)=1, else IDLE.
REQ-022 Start asserted while Busy=1 SHALL be ignored; changes on En0/En1 during a scan SHALL not affect that scan.
REQ-023 S SHALL hold its last value in IDLE and change only on a channel transition or scan start.
REQ-024 Latency, both channels enabled: Valid SHALL be high in the cycle 2*(SETTLE+DWELL)+1 edges after the Start-sampling edge; with one channel enabled: (SETTLE+DWELL)+1.

Reset
REQ-025 Reset_n=0 on a rising edge SHALL force IDLE and S=0, Sample0=0, Sample1=0, Valid=0, Busy=0, and clear all counters and latched enables, from any state including mid-scan.
REQ-026 Reset SHALL take priority over Start, Cont, and all FSM transitions in the same cycle.

Verification
REQ-027 DWELL=4, SETTLE=1, En0=En1=1, Start pulse; Y=1 throughout ch0, Y=1,0,0,1 during ch1 DWELL -> Sample0=1, Sample1=0 (tie), Valid pulses 11 edges after Start, S sequence 0 then 1.
REQ-028 En0=0, En1=1, Start -> S=1 from the first cycle, Y=1,1,1,0 -> Sample1=1, Sample0 unchanged, Valid after 6 edges.
REQ-029 En0=En1=0, Start -> Busy stays 0, no Valid pulse; then Start during a scan -> scan timing unchanged.
REQ-030 Cont=1, both channels enabled -> back-to-back Valid pulses every 11 cycles, Busy never drops; Cont=0 mid-scan -> IDLE after the next DONE.
REQ-031 Reset_n=0 during ch1 DWELL -> next cycle all outputs 0, state IDLE; a fresh Start then completes normally.
REQ-032 SETTLE=0, DWELL=1 -> each channel takes 1 cycle, Sample=Y, Valid 3 edges after Start.
